// File: rtl/uart_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_boot_loader: UART byte stream -> 32-bit BRAM words, holds CPU in reset |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module uart_boot_loader #(
  parameter int          ADDR_W  = 13,
  parameter int          TIMEOUT = 1000000,
  parameter logic [7:0]  MAGIC   = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_boot_en,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic [3:0]        o_mem_we,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int                 C_TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT - 1);
  localparam logic [16:0]        C_MAX_CNT  = 17'(1) << ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [23:0]        word_q, word_d;
  logic [1:0]         b_q, b_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [C_TMR_W-1:0] tmr_q, tmr_d;
  logic               err_q, err_d;
  logic [3:0]         mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_data_q, mem_data_d;

  logic        w_active;
  logic        w_timeout;
  logic        w_magic;
  logic [15:0] w_cnt_full;
  logic [31:0] w_word_full;

  assign w_active    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
  assign w_timeout   = w_active && !i_rx_valid && (tmr_q == C_TMR_LAST);
  assign w_magic     = i_boot_en && i_rx_valid && (i_rx_data == MAGIC);
  assign w_cnt_full  = {i_rx_data, cnt_q[7:0]};
  assign w_word_full = {i_rx_data, word_q};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!i_boot_en)   state_d = S_DONE;
        else if (w_magic) state_d = S_LEN_LO;
      end
      S_LEN_LO: if (i_rx_valid) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (i_rx_valid) begin
          if ({1'b0, w_cnt_full} > C_MAX_CNT) state_d = S_ERR;
          else if (w_cnt_full == 16'd0)       state_d = S_CSUM;
          else                                state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_rx_valid && (b_q == 2'd3) && (cnt_q == 16'd1)) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (i_rx_valid) state_d = (i_rx_data == sum_q) ? S_DONE : S_ERR;
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (w_timeout) state_d = S_ERR;
  end

  // Outputs
  always_comb begin
    o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    o_done     = (state_q == S_DONE);
    o_cpu_rst  = (state_q != S_DONE);
    o_err      = err_q;
    o_mem_we   = mem_we_q;
    o_mem_addr = mem_addr_q;
    o_mem_data = mem_data_q;
  end

  // Datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    word_d     = word_q;
    b_d        = b_q;
    addr_d     = addr_q;
    err_d      = err_q;
    mem_we_d   = 4'h0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;

    if (!w_active || i_rx_valid)   tmr_d = '0;
    else if (tmr_q != C_TMR_LAST)  tmr_d = tmr_q + 1'b1;
    else                           tmr_d = tmr_q;

    case (state_q)
      S_IDLE: begin
        if (w_magic) begin
          err_d = 1'b0;
          sum_d = 8'd0;
        end
      end
      S_LEN_LO: if (i_rx_valid) cnt_d[7:0] = i_rx_data;
      S_LEN_HI: begin
        if (i_rx_valid) begin
          cnt_d  = w_cnt_full;
          addr_d = '0;
          b_d    = 2'd0;
          sum_d  = 8'd0;
        end
      end
      S_DATA: begin
        if (i_rx_valid) begin
          word_d = {i_rx_data, word_q[23:8]};
          sum_d  = sum_q + i_rx_data;
          b_d    = b_q + 1'b1;
          // Fourth byte completes the word; the write pulse appears next cycle
          if (b_q == 2'd3) begin
            mem_we_d   = 4'hF;
            mem_addr_d = addr_q;
            mem_data_d = w_word_full;
            addr_d     = addr_q + 1'b1;
            cnt_d      = cnt_q - 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (state_d == S_ERR) err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      sum_q      <= '0;
      word_q     <= '0;
      b_q        <= '0;
      addr_q     <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      mem_we_q   <= 4'h0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      word_q     <= word_d;
      b_q        <= b_d;
      addr_q     <= addr_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule
`default_nettype wire
